// File: rtl/booth_seq_mult_ctrl_if.sv
// Operand/result bundle between the issuing master and the Booth multiplier.
interface booth_seq_mult_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-2 Booth signed multiplier: one add/sub + shift per clock,
// WIDTH steps per operation, registered product with a one-cycle done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one Booth step per cycle; leaves on the step with cnt == 0
module booth_seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    booth_seq_mult_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]           state;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH:0]       a_reg;
    logic [WIDTH-1:0]     q_reg;
    logic                 q_m1;
    logic [CW-1:0]        cnt;
    logic                 done_r;
    logic [2*WIDTH-1:0]   product_r;

    // A is one bit wider than the operands so that subtracting the most
    // negative multiplicand cannot overflow.
    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       a_sum;
    logic [WIDTH:0]       a_next;
    logic [WIDTH-1:0]     q_next;

    // Booth add/sub selected by {Q[0], q_-1}, followed by the arithmetic shift.
    always_comb begin
        m_ext = {m_reg[WIDTH-1], m_reg};
        a_sum = a_reg;
        case ({q_reg[0], q_m1})
            2'b01:   a_sum = a_reg + m_ext;
            2'b10:   a_sum = a_reg - m_ext;
            default: a_sum = a_reg;
        endcase
        a_next = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_next = {a_sum[0], q_reg[WIDTH-1:1]};
    end

    // Controller and datapath registers; done defaults low so it pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_reg <= bus.multiplicand;
                        a_reg <= '0;
                        q_reg <= bus.multiplier;
                        q_m1  <= 1'b0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_m1  <= q_reg[0];
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        product_r <= {a_next[WIDTH-1:0], q_next};
                        done_r    <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Directed bench for the sequential Booth multiplier (WIDTH = 8).
module tb_booth_seq_mult_ctrl;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    booth_seq_mult_ctrl_if #(.WIDTH(8)) bus ();

    booth_seq_mult_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full operation: accept, wait bounded for done, check latency,
    // product, busy during RUN and that done is a single-cycle pulse.
    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, input string name);
        int lat;
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_after_accept got=%b want=1", name, bus.busy);
        end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL %s latency got=%0d want=8", name, lat);
        end
        tests++;
        if (bus.product !== exp) begin
            fails++;
            $display("FAIL %s product got=%h want=%h", name, bus.product, exp);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy_at_done got=%b want=0", name, bus.busy);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b0 || bus.product !== exp) begin
            fails++;
            $display("FAIL %s done_pulse/hold got done=%b prod=%h want done=0 prod=%h",
                     name, bus.done, bus.product, exp);
        end
    endtask

    task automatic test_reset();
        int dones;
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
            fails++;
            $display("FAIL reset_state got busy=%b done=%b prod=%h want 0 0 0000",
                     bus.busy, bus.done, bus.product);
        end
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        tests++;
        if (dones !== 0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_done got dones=%0d busy=%b want 0 0", dones, bus.busy);
        end
    endtask

    task automatic test_corners();
        run_op(8'h7F, 8'h7F, 16'h3F01, "c_7Fx7F");
        run_op(8'h7F, 8'h80, 16'hC080, "c_7Fx80");
        run_op(8'h80, 8'h7F, 16'hC080, "c_80x7F");
        run_op(8'h80, 8'h80, 16'h4000, "c_80x80");
        run_op(8'h00, 8'h00, 16'h0000, "c_00x00");
        run_op(8'h01, 8'h80, 16'hFF80, "c_01x80");
    endtask

    task automatic test_mixed();
        logic [7:0]  sq [6];
        logic [15:0] sp [6];
        sq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
        sp = '{16'h0055, 16'h00AA, 16'h0154, 16'h02A8, 16'h0550, 16'h0AA0};
        run_op(8'h77, 8'hC4, 16'hE41C, "m_77xC4");
        run_op(8'hF7, 8'hC4, 16'h021C, "m_F7xC4");
        run_op(8'h40, 8'h20, 16'h0800, "m_40x20");
        for (int i = 0; i < 6; i++) run_op(8'h55, sq[i], sp[i], "sweep_55");
    endtask

    task automatic test_busy_interference();
        int lat;
        int dones;
        bit busy_drop;
        bus.start = 1'b1; bus.multiplicand = 8'h7F; bus.multiplier = 8'hC5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; dones = 0; busy_drop = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                bus.start = 1'b1; bus.multiplicand = 8'h01; bus.multiplier = 8'h01;
            end
            if (c == 4) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                dones++;
                if (lat == 0) begin
                    lat = c;
                    tests++;
                    if (bus.product !== 16'hE2BB) begin
                        fails++;
                        $display("FAIL busy_intf product got=%h want=E2BB", bus.product);
                    end
                end
            end
            if (c < 8 && bus.busy !== 1'b1) busy_drop = 1;
        end
        tests++;
        if (dones !== 1 || lat !== 8) begin
            fails++;
            $display("FAIL busy_intf dones got=%0d lat=%0d want 1 8", dones, lat);
        end
        tests++;
        if (busy_drop) begin
            fails++;
            $display("FAIL busy_intf busy_continuous got=dropped want=held");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  am [5];
        logic [7:0]  aq [5];
        logic [15:0] ap [5];
        int cyc;
        int last_done;
        am = '{8'h7F, 8'h80, 8'h77, 8'hF7, 8'h00};
        aq = '{8'h7F, 8'h80, 8'hC4, 8'hC4, 8'h00};
        ap = '{16'h3F01, 16'h4000, 16'hE41C, 16'h021C, 16'h0000};
        bus.start = 1'b1; bus.multiplicand = am[0]; bus.multiplier = aq[0];
        @(posedge clk); #1;
        cyc = 0; last_done = 0;
        bus.multiplicand = am[1]; bus.multiplier = aq[1];
        for (int k = 0; k < 4; k++) begin
            int guard;
            guard = 0;
            while (bus.done !== 1'b1 && guard < 20) begin
                @(posedge clk); #1;
                cyc++; guard++;
            end
            if (k == 3) bus.start = 1'b0;
            tests++;
            if (bus.product !== ap[k]) begin
                fails++;
                $display("FAIL b2b product[%0d] got=%h want=%h", k, bus.product, ap[k]);
            end
            tests++;
            if (cyc - last_done !== ((k == 0) ? 8 : 9)) begin
                fails++;
                $display("FAIL b2b spacing[%0d] got=%0d want=%0d", k, cyc - last_done,
                         (k == 0) ? 8 : 9);
            end
            last_done = cyc;
            @(posedge clk); #1;
            cyc++;
            if (k < 3) begin
                tests++;
                if (bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b reaccept[%0d] busy got=%b want=1", k, bus.busy);
                end
                bus.multiplicand = am[k+2]; bus.multiplier = aq[k+2];
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
        for (int i = 0; i < 150; i++) begin
            m = 8'($urandom);
            q = 8'($urandom);
            exp = 16'($signed(m) * $signed(q));
            run_op(m, q, exp, "random");
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        bus.start = 1'b1; bus.multiplicand = 8'h7F; bus.multiplier = 8'h7F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 16'h0000) begin
            fails++;
            $display("FAIL midrun_reset got busy=%b done=%b prod=%h want 0 0 0000",
                     bus.busy, bus.done, bus.product);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        tests++;
        if (dones !== 0 || bus.product !== 16'h0000) begin
            fails++;
            $display("FAIL midrun_abort got dones=%0d prod=%h want 0 0000", dones, bus.product);
        end
        run_op(8'h80, 8'h01, 16'hFF80, "post_reset_80x01");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        #2;
        test_reset();
        test_corners();
        test_mixed();
        test_busy_interference();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
